// File: rtl/miso_packet_rx_if.sv
// Packet handshake bundle between the miso deframer (master) and the packet consumer (slave).
interface miso_packet_rx_if #(
    parameter int WIDTH = 54
);
    logic [WIDTH-1:0] packet_out;
    logic             packet_parity_ok;
    logic             packet_valid;
    logic             packet_ready;

    modport master (
        output packet_out,
        output packet_parity_ok,
        output packet_valid,
        input  packet_ready
    );

    modport slave (
        input  packet_out,
        input  packet_parity_ok,
        input  packet_valid,
        output packet_ready
    );
endinterface

// File: rtl/miso_packet_rx.sv
// LArPix miso UART deframer: 2x oversampled, odd-parity check, small output packet FIFO.
// Optional error counters are enabled by defining RX_ERR_COUNT_EN.
module miso_packet_rx #(
    parameter int WIDTH      = 54,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk2x,
    input  logic                  reset_n,
    input  logic                  miso,
    miso_packet_rx_if.master      pkt,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  overflow
`ifdef RX_ERR_COUNT_EN
    ,
    input  logic                  clear_counters,
    output logic [CNT_W-1:0]      frame_err_count,
    output logic [CNT_W-1:0]      parity_err_count,
    output logic [CNT_W-1:0]      overflow_count
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("miso_packet_rx: FIFO_DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
    end

    // ------------------------------------------------------------------
    // Input synchroniser (idles high so reset never looks like a start)
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic miso_s;

    always_ff @(posedge clk2x or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= miso;
            sync2_q <= sync1_q;
        end
    end

    assign miso_s = sync2_q;

    // ------------------------------------------------------------------
    // Deframing FSM
    // ------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             push;
    logic             ferr_d;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        phase_d  = phase_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!miso_s) state_d = S_START;
            end
            S_START: begin
                if (!miso_s) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                    phase_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    shreg_d[bitcnt_q] = miso_s;
                    bitcnt_d          = bitcnt_q + 1'b1;
                    if (bitcnt_q == BCW'(WIDTH - 1)) state_d = S_STOP;
                end
            end
            S_STOP: begin
                // phase is 0 on entry, so the stop sample lands mid stop bit
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (miso_s) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (miso_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk2x or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            phase_q  <= 1'b0;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            phase_q  <= phase_d;
            shreg_q  <= shreg_d;
        end
    end

    assign rx_busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Output FIFO: extra pointer bit separates full from empty
    // ------------------------------------------------------------------
    logic [WIDTH:0] mem_q [FIFO_DEPTH];
    logic [AW:0]    wptr_q, wptr_d;
    logic [AW:0]    rptr_q, rptr_d;
    logic           empty, full, pop, wr_en, ovf_d;
    logic           parity_ok;
    logic [WIDTH:0] head;

    assign parity_ok = ^shreg_q;
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop       = !empty && pkt.packet_ready;
    // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
    assign wr_en     = push && (!full || pop);
    assign ovf_d     = push && full && !pop;
    assign wptr_d    = wr_en ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d    = pop   ? rptr_q + 1'b1 : rptr_q;

    always_ff @(posedge clk2x) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= {parity_ok, shreg_q};
    end

    always_ff @(posedge clk2x or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign head                 = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign pkt.packet_out       = head[WIDTH-1:0];
    assign pkt.packet_parity_ok = head[WIDTH];
    assign pkt.packet_valid     = !empty;

    // ------------------------------------------------------------------
    // Registered error pulses (push and stop-error are exclusive)
    // ------------------------------------------------------------------
    logic ferr_q, ovf_q;

    always_ff @(posedge clk2x or negedge reset_n) begin
        if (!reset_n) begin
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

`ifdef RX_ERR_COUNT_EN
    // ------------------------------------------------------------------
    // Saturating error counters; clear wins over a same-cycle event
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] fe_cnt_q, pe_cnt_q, ov_cnt_q;
    logic             pe_evt;

    assign pe_evt = wr_en && !parity_ok;

    always_ff @(posedge clk2x or negedge reset_n) begin
        if (!reset_n) begin
            fe_cnt_q <= '0;
            pe_cnt_q <= '0;
            ov_cnt_q <= '0;
        end else if (clear_counters) begin
            fe_cnt_q <= '0;
            pe_cnt_q <= '0;
            ov_cnt_q <= '0;
        end else begin
            if (ferr_d && fe_cnt_q != '1) fe_cnt_q <= fe_cnt_q + 1'b1;
            if (pe_evt && pe_cnt_q != '1) pe_cnt_q <= pe_cnt_q + 1'b1;
            if (ovf_d  && ov_cnt_q != '1) ov_cnt_q <= ov_cnt_q + 1'b1;
        end
    end

    assign frame_err_count  = fe_cnt_q;
    assign parity_err_count = pe_cnt_q;
    assign overflow_count   = ov_cnt_q;
`endif

endmodule
